// File: rtl/seg_pkg.sv
// Segment glyph constants shared by the display driver and its decoder.
// All glyphs are active-low, bit6 = g ... bit0 = a.
package seg_pkg;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_ERR = 7'h36;
  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to 7-segment decoder (active-low).
// Codes 10-15 show A b C d E F when hex_en=1, otherwise the error glyph.
module seg7_decode
  import seg_pkg::*;
(
  input  logic       hex_en,
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Glyph lookup; hex letters fall back to the error glyph in BCD mode.
  always_comb begin
    seg_n = SEG_ERR;
    case (nibble)
      4'h0:    seg_n = SEG_0;
      4'h1:    seg_n = SEG_1;
      4'h2:    seg_n = SEG_2;
      4'h3:    seg_n = SEG_3;
      4'h4:    seg_n = SEG_4;
      4'h5:    seg_n = SEG_5;
      4'h6:    seg_n = SEG_6;
      4'h7:    seg_n = SEG_7;
      4'h8:    seg_n = SEG_8;
      4'h9:    seg_n = SEG_9;
      4'hA:    seg_n = hex_en ? SEG_A : SEG_ERR;
      4'hB:    seg_n = hex_en ? SEG_B : SEG_ERR;
      4'hC:    seg_n = hex_en ? SEG_C : SEG_ERR;
      4'hD:    seg_n = hex_en ? SEG_D : SEG_ERR;
      4'hE:    seg_n = hex_en ? SEG_E : SEG_ERR;
      4'hF:    seg_n = hex_en ? SEG_F : SEG_ERR;
      default: seg_n = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver.
// Double-buffers the display value (pending -> shadow at frame end), scans one
// digit per slot with a dark anti-ghost window at the start of each slot, and
// applies leading-zero blanking. All pin outputs are registered.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NDIG      = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4*NDIG-1:0] value,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              load,
  input  logic              hex_en,
  input  logic              lz_blank,
  output logic [6:0]        seg_n,
  output logic              dp_n,
  output logic [NDIG-1:0]   an_n,
  output logic              frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int BW = 5 * NDIG;  // {dp bits, value nibbles}

  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [BW-1:0]   pend_q, pend_d;
  logic [BW-1:0]   shadow_q, shadow_d;
  logic            pend_flag_q, pend_flag_d;
  logic            tick_s, wrap_s, blank_s;
  logic            zero_above_s;
  logic [NDIG-1:0] lz_mask_s;
  logic [NDIG-1:0] an_sel_s;
  logic [3:0]      nib_s;
  logic            dp_s, lz_hide_s;
  logic [6:0]      dec_seg_s;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [NDIG-1:0] an_q, an_d;
  logic            fd_q, fd_d;

  // Slot prescaler and digit index; wrap marks the end of the last slot.
  always_comb begin
    tick_s = (pcnt_q == PW'(SCAN_DIV - 1));
    wrap_s = tick_s && (idx_q == IW'(NDIG - 1));
    pcnt_d = tick_s ? '0 : pcnt_q + PW'(1);
    if (tick_s) begin
      idx_d = wrap_s ? '0 : idx_q + IW'(1);
    end else begin
      idx_d = idx_q;
    end
  end

  // Pending/shadow buffering: shadow only moves at frame boundaries so a frame never tears.
  always_comb begin
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    shadow_d    = shadow_q;
    if (load && wrap_s) begin
      pend_d      = {dp_in, value};
      shadow_d    = {dp_in, value};
      pend_flag_d = 1'b0;
    end else if (load) begin
      pend_d      = {dp_in, value};
      pend_flag_d = 1'b1;
    end else if (wrap_s && pend_flag_q) begin
      shadow_d    = pend_q;
      pend_flag_d = 1'b0;
    end else begin
      pend_flag_d = pend_flag_q;
    end
  end

  // Leading-zero mask: walk from the top digit down while nibbles and dp bits stay zero.
  always_comb begin
    zero_above_s = 1'b1;
    lz_mask_s    = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_above_s = zero_above_s && (shadow_q[4*i +: 4] == 4'h0) && !shadow_q[4*NDIG + i];
      lz_mask_s[i] = lz_blank && (i != 0) && zero_above_s;
    end
  end

  // Select the scanned digit's nibble, dp and blanking flag, and its enable pattern.
  always_comb begin
    nib_s     = 4'h0;
    dp_s      = 1'b0;
    lz_hide_s = 1'b0;
    an_sel_s  = '1;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) begin
        nib_s       = shadow_q[4*i +: 4];
        dp_s        = shadow_q[4*NDIG + i];
        lz_hide_s   = lz_mask_s[i];
        an_sel_s[i] = 1'b0;
      end else begin
        an_sel_s[i] = 1'b1;
      end
    end
  end

  seg7_decode u_dec (
    .hex_en (hex_en),
    .nibble (nib_s),
    .seg_n  (dec_seg_s)
  );

  // Next output values: dark during the anti-ghost window, otherwise the scanned digit.
  always_comb begin
    blank_s = (pcnt_q < PW'(BLANK_CYC));
    fd_d    = wrap_s;
    if (blank_s) begin
      an_d  = '1;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end else begin
      an_d  = an_sel_s;
      seg_d = lz_hide_s ? SEG_OFF : dec_seg_s;
      dp_d  = !dp_s;
    end
  end

  // Scan state and display buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q      <= '0;
      idx_q       <= '0;
      pend_q      <= '0;
      shadow_q    <= '0;
      pend_flag_q <= 1'b0;
    end else begin
      pcnt_q      <= pcnt_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      shadow_q    <= shadow_d;
      pend_flag_q <= pend_flag_d;
    end
  end

  // Registered pin outputs; reset drives the display dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
      an_q  <= '1;
      fd_q  <= 1'b0;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
      fd_q  <= fd_d;
    end
  end

  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign an_n       = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (NDIG=4, SCAN_DIV=4, BLANK_CYC=1).
// A frame-level reference model pushes the expected pin state for every cycle
// in which a digit is lit or frame_done is set; a monitor pops and compares.
module tb_seg_scan_driver;

  localparam int NDIG      = 4;
  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;
  localparam int FRAME     = NDIG * SCAN_DIV;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        hex_en;
  logic        lz_blank;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int          n_chk;
  int          n_fail;
  exp_t        exp_q[$];
  logic [6:0]  glyph [16];

  // model state: frame-level view of what is on display and what is waiting
  int unsigned mc;
  logic [15:0] m_val, p_val;
  logic [3:0]  m_dp, p_dp;
  logic        m_pend;

  seg_scan_driver #(
    .NDIG      (NDIG),
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .hex_en     (hex_en),
    .lz_blank   (lz_blank),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int slot, input logic [15:0] v, input logic [3:0] d,
                                         input logic hx, input logic lz);
    logic [15:0] above;
    logic [3:0]  dabove;
    int          nib;
    above  = v >> (4 * slot);
    dabove = d >> slot;
    nib    = int'(above & 16'h000F);
    if (lz && slot > 0 && above == 16'h0 && dabove == 4'h0) return 7'h7F;
    if (nib > 9 && !hx) return 7'h36;
    return glyph[nib];
  endfunction

  // Reference model: cycle n after reset release shows slot (n/SCAN_DIV)%NDIG, phase n%SCAN_DIV.
  initial begin
    int   p, slot, ph;
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mc = 0; m_val = 16'h0; m_dp = 4'h0; p_val = 16'h0; p_dp = 4'h0; m_pend = 1'b0;
        exp_q.delete();
      end else begin
        p    = int'(mc % FRAME);
        slot = p / SCAN_DIV;
        ph   = p % SCAN_DIV;
        e.fd = (p == FRAME - 1);
        if (ph < BLANK_CYC) begin
          e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
        end else begin
          e.an       = 4'hF;
          e.an[slot] = 1'b0;
          e.dp       = ~m_dp[slot];
          e.seg      = exp_seg(slot, m_val, m_dp, hex_en, lz_blank);
        end
        if (e.an != 4'hF || e.fd) exp_q.push_back(e);
        if (p == FRAME - 1) begin
          if (load) begin
            m_val = value; m_dp = dp_in;
          end else if (m_pend) begin
            m_val = p_val; m_dp = p_dp;
          end
          m_pend = 1'b0;
        end else if (load) begin
          p_val = value; p_dp = dp_in; m_pend = 1'b1;
        end
        mc++;
      end
    end
  end

  // Monitor: compare whenever the DUT presents a lit digit or frame_done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (an_n != 4'hF || frame_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {an_n, seg_n, dp_n, frame_done}, 16'h0);
        end else begin
          e = exp_q.pop_front();
          check("an_n", {12'h0, an_n}, {12'h0, e.an});
          check("seg_n", {9'h0, seg_n}, {9'h0, e.seg});
          check("dp_n", {15'h0, dp_n}, {15'h0, e.dp});
          check("frame_done", {15'h0, frame_done}, {15'h0, e.fd});
        end
      end else begin
        check("dark_pins", {8'h0, seg_n, dp_n}, {8'h0, 7'h7F, 1'b1});
      end
    end
  end

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    @(posedge clk); #1;
    value = v; dp_in = d; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] v;
    int          hit;
    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; value = 16'h0; dp_in = 4'h0; load = 1'b0; hex_en = 1'b0; lz_blank = 1'b0;
    #12;
    check("rst_an_n", {12'h0, an_n}, 16'h000F);
    check("rst_seg_n", {9'h0, seg_n}, 16'h007F);
    check("rst_dp_n", {15'h0, dp_n}, 16'h0001);
    check("rst_frame_done", {15'h0, frame_done}, 16'h0000);
    rst_n = 1'b1;

    // basic BCD digits
    do_load(16'h1234, 4'h0);
    run(40);
    // hex letters, then live switch to error glyph
    hex_en = 1'b1;
    do_load(16'hABCF, 4'h0);
    run(40);
    hex_en = 1'b0;
    run(20);
    // leading-zero blanking, then dp stops blanking at digit 2
    lz_blank = 1'b1;
    do_load(16'h0005, 4'h0);
    run(40);
    do_load(16'h0005, 4'b0100);
    run(40);
    lz_blank = 1'b0;
    // newer load overwrites pending mid-frame
    do_load(16'h1111, 4'h0);
    run(6);
    do_load(16'h2222, 4'h0);
    run(40);
    // load exactly on the wrap cycle
    hit = 0;
    for (int k = 0; k < 40 && hit == 0; k++) begin
      @(posedge clk); #1;
      if (mc % FRAME == FRAME - 1) hit = 1;
    end
    check("wrap_found", hit[15:0], 16'h0001);
    value = 16'h9876; dp_in = 4'h0; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    run(20);

    // randomized loads and live mode toggles
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      load = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        v = 16'($urandom);
        case ($urandom_range(0, 4))
          0:       v = v & 16'h000F;
          1:       v = v & 16'h00FF;
          2:       v = v & 16'h0FFF;
          default: v = v;
        endcase
        value = v;
        dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        load  = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) hex_en = ~hex_en;
      if ($urandom_range(0, 49) == 0) lz_blank = ~lz_blank;
    end
    load = 1'b0;
    run(20);

    // asynchronous reset while a digit is lit
    hit = 0;
    for (int k = 0; k < 40 && hit == 0; k++) begin
      @(negedge clk);
      if (an_n != 4'hF) hit = 1;
    end
    check("lit_before_reset", hit[15:0], 16'h0001);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_an_n", {12'h0, an_n}, 16'h000F);
    check("async_rst_seg_n", {9'h0, seg_n}, 16'h007F);
    check("async_rst_dp_n", {15'h0, dp_n}, 16'h0001);
    hex_en = 1'b0; lz_blank = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_blank_an", {12'h0, an_n}, 16'h000F);
    @(posedge clk); #1;
    check("post_rst_digit0_an", {12'h0, an_n}, 16'h000E);
    check("post_rst_digit0_seg", {9'h0, seg_n}, 16'h0040);
    check("post_rst_digit0_dp", {15'h0, dp_n}, 16'h0001);
    run(40);

    @(negedge clk); #1;
    check("queue_drained", exp_q.size(), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
